avalon_mm_arbiter: RTL and testbench

Sits directly downstream of the CPU's two Avalon-MM host ports: the data read/write port and the instruction read-only port. Merges them onto a single pipelined Avalon-MM host port driving one shared memory or interconnect. Round-robin arbitration holds the grant while the selected request is stalled. A tag FIFO records which port issued each outstanding read, so every returning readdatavalid is routed to the port that issued it.

---
 rtl/avalon_mm_arbiter_pkg.sv | 25 ++
 rtl/avalon_mm_arbiter_if.sv | 24 ++
 rtl/avalon_mm_arbiter_tag_fifo.sv | 59 +++++
 rtl/avalon_mm_arbiter.sv | 121 ++++++++++++
 tb/tb_avalon_mm_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_mm_arbiter_pkg.sv
// Shared types for the two-host Avalon-MM arbiter: bus word, request bundle and
// the tag naming which host port issued an outstanding read.
package avalon_mm_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  typedef enum logic {
    PortData  = 1'b0,
    PortInstr = 1'b1
  } port_t;

  typedef struct packed {
    word_t address;
    be_t   byteenable;
    logic  read;
    logic  write;
    word_t writedata;
  } req_t;

  function automatic port_t other_port(input port_t p);
    return (p == PortData) ? PortInstr : PortData;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_if.sv
// One pipelined Avalon-MM link. The host side uses master, the agent side slave.
interface avalon_mm_arbiter_if;
  import avalon_mm_arbiter_pkg::*;

  word_t address;
  be_t   byteenable;
  logic  read;
  logic  write;
  word_t writedata;
  logic  waitrequest;
  word_t readdata;
  logic  readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/avalon_mm_arbiter_tag_fifo.sv
// Synchronous FIFO of port tags; pointers are {wrap, index} so full and empty
// are distinguishable at any depth, including non-powers of two.
module avalon_mm_arbiter_tag_fifo
  import avalon_mm_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  port_t push_tag,
  input  logic  pop,
  output port_t head,
  output logic  full,
  output logic  empty
);

  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = IW + 1;
  localparam int IWS = (IW > 0) ? IW : 1;

  typedef logic [PW-1:0]  ptr_t;
  typedef logic [IWS-1:0] idx_t;

  function automatic idx_t idx_of(input ptr_t p);
    return idx_t'(int'(p) % (1 << IW));
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (int'(idx_of(p)) == DEPTH - 1)
      return p[PW-1] ? '0 : ptr_t'(1 << IW);
    return p + ptr_t'(1);
  endfunction

  port_t mem [DEPTH];
  ptr_t  wr_ptr, rd_ptr;
  logic  do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (idx_of(wr_ptr) == idx_of(rd_ptr)) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[idx_of(rd_ptr)];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[idx_of(wr_ptr)] <= push_tag;
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Merges the CPU data and instruction host ports onto one pipelined Avalon-MM
// host port; read responses are steered back by a tag FIFO in issue order.
module avalon_mm_arbiter
  import avalon_mm_arbiter_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  avalon_mm_arbiter_if.slave   d_bus,
  avalon_mm_arbiter_if.slave   i_bus,
  avalon_mm_arbiter_if.master  m_bus
);

  if (MAX_PENDING < 1) begin : g_bad_depth
    $error("MAX_PENDING must be >= 1");
  end

  req_t  d_r, i_r, sel_r;
  logic  d_req, i_req, any_req;
  port_t sel, owner_q, last_grant;
  logic  locked;
  logic  fifo_full, fifo_empty, blocked, own_wait, accept, push, pop;
  port_t head;

  // A simultaneous read+write on the data port is resolved as a write.
  always_comb begin
    d_r = '{address: d_bus.address, byteenable: d_bus.byteenable,
            read: d_bus.read & ~d_bus.write, write: d_bus.write,
            writedata: d_bus.writedata};
    i_r = '{address: i_bus.address, byteenable: i_bus.byteenable,
            read: i_bus.read, write: 1'b0, writedata: '0};
  end

  assign d_req = d_bus.read | d_bus.write;
  assign i_req = i_bus.read;

  always_comb begin
    sel     = owner_q;
    any_req = 1'b0;
    if (locked) begin
      sel     = owner_q;
      any_req = (owner_q == PortData) ? d_req : i_req;
    end else if (d_req && i_req) begin
      sel     = other_port(last_grant);
      any_req = 1'b1;
    end else if (d_req) begin
      sel     = PortData;
      any_req = 1'b1;
    end else if (i_req) begin
      sel     = PortInstr;
      any_req = 1'b1;
    end
  end

  assign sel_r = (sel == PortData) ? d_r : i_r;

  // Full blocks a read even if a pop lands this cycle, so readdatavalid
  // never reaches waitrequest combinationally.
  assign blocked  = any_req && sel_r.read && fifo_full;
  assign own_wait = m_bus.waitrequest | blocked;

  always_comb begin
    m_bus.address    = sel_r.address;
    m_bus.byteenable = sel_r.byteenable;
    m_bus.writedata  = sel_r.writedata;
    m_bus.read       = rst && any_req && sel_r.read && !fifo_full;
    m_bus.write      = rst && any_req && sel_r.write;
  end

  assign accept = (m_bus.read | m_bus.write) && !m_bus.waitrequest;
  assign push   = accept && m_bus.read;
  assign pop    = m_bus.readdatavalid && !fifo_empty;

  always_comb begin
    d_bus.waitrequest   = !rst || !(any_req && sel == PortData)  || own_wait;
    i_bus.waitrequest   = !rst || !(any_req && sel == PortInstr) || own_wait;
    d_bus.readdata      = m_bus.readdata;
    i_bus.readdata      = m_bus.readdata;
    d_bus.readdatavalid = rst && pop && (head == PortData);
    i_bus.readdatavalid = rst && pop && (head == PortInstr);
  end

  // Grant is held across stalls so the stalled host keeps its request on m_*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PortInstr;
      owner_q    <= PortData;
      locked     <= 1'b0;
    end else if (accept) begin
      last_grant <= sel;
      owner_q    <= sel;
      locked     <= 1'b0;
    end else if (any_req) begin
      owner_q    <= sel;
      locked     <= 1'b1;
    end else begin
      locked     <= 1'b0;
    end
  end

  avalon_mm_arbiter_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (sel),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  logic unused_i_wr;
  assign unused_i_wr = ^{i_bus.write, i_bus.writedata};

  a_rdv_empty: assert property (@(posedge clk) disable iff (!rst)
    !(m_bus.readdatavalid && fifo_empty));
  a_d_rd_wr: assert property (@(posedge clk) disable iff (!rst)
    !(d_bus.read && d_bus.write));

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed protocol steps followed by randomized two-host traffic against an
// in-order memory responder and per-host expectation queues.
module tb_avalon_mm_arbiter;
  import avalon_mm_arbiter_pkg::*;

  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_mm_arbiter_if d_bus ();
  avalon_mm_arbiter_if i_bus ();
  avalon_mm_arbiter_if m_bus ();

  avalon_mm_arbiter #(.MAX_PENDING(MAXP)) dut (
    .clk   (clk),
    .rst   (rst),
    .d_bus (d_bus),
    .i_bus (i_bus),
    .m_bus (m_bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic drv_d(input logic rd, input logic wr, input word_t a, input be_t be, input word_t wd);
    d_bus.read = rd; d_bus.write = wr; d_bus.address = a; d_bus.byteenable = be; d_bus.writedata = wd;
  endtask

  task automatic drv_i(input logic rd, input word_t a);
    i_bus.read = rd; i_bus.address = a; i_bus.byteenable = 4'hF;
    i_bus.write = 1'b0; i_bus.writedata = '0;
  endtask

  task automatic drv_m(input logic wt, input logic rdv, input word_t rdata);
    m_bus.waitrequest = wt; m_bus.readdatavalid = rdv; m_bus.readdata = rdata;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".m_read"},  m_bus.read, 0);
    chk({tag, ".m_write"}, m_bus.write, 0);
    chk({tag, ".d_wait"},  d_bus.waitrequest, 1);
    chk({tag, ".i_wait"},  i_bus.waitrequest, 1);
    chk({tag, ".d_rdv"},   d_bus.readdatavalid, 0);
    chk({tag, ".i_rdv"},   i_bus.readdatavalid, 0);
  endtask

  function automatic word_t memf(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  typedef struct { word_t data; int rdy; } rsp_t;

  word_t d_rq[$], i_rq[$];
  req_t  dw_q[$];
  port_t order[$];
  rsp_t  mq[$];

  initial begin
    logic  d_act, i_act, d_acc, i_acc, m_acc;
    req_t  d_cur, i_cur, w;
    word_t a;
    port_t p;
    int    cyc;

    // ---- reset forces outputs even with requests present
    rst = 1'b0;
    drv_d(1, 0, 32'h10, 4'hF, 0); drv_i(1, 32'h20); drv_m(0, 1, 32'h1);
    #1 chk_reset_outs("in_reset");
    repeat (2) @(negedge clk);
    drv_d(0, 0, 0, 0, 0); drv_i(0, 0); drv_m(0, 0, 0);
    rst = 1'b1;
    #1 chk_reset_outs("idle");

    // ---- simultaneous reads: data first on the tie, then instruction
    @(negedge clk);
    drv_d(1, 0, 32'h100, 4'hF, 0); drv_i(1, 32'h200);
    #1 chk("tie.m_addr", m_bus.address, 32'h100); chk("tie.m_read", m_bus.read, 1);
    chk("tie.d_wait", d_bus.waitrequest, 0); chk("tie.i_wait", i_bus.waitrequest, 1);
    @(negedge clk);
    drv_d(0, 0, 0, 0, 0); drv_m(0, 1, 32'hAAAA);
    #1 chk("tie2.m_addr", m_bus.address, 32'h200); chk("tie2.i_wait", i_bus.waitrequest, 0);
    chk("tie2.d_rdv", d_bus.readdatavalid, 1); chk("tie2.d_data", d_bus.readdata, 32'hAAAA);
    chk("tie2.i_rdv", i_bus.readdatavalid, 0);
    @(negedge clk);
    drv_i(0, 0); drv_m(0, 1, 32'hBBBB);
    #1 chk("tie3.i_rdv", i_bus.readdatavalid, 1); chk("tie3.i_data", i_bus.readdata, 32'hBBBB);
    chk("tie3.d_rdv", d_bus.readdatavalid, 0);

    // ---- grant held while stalled; data write waits its turn
    @(negedge clk);
    drv_m(1, 0, 0); drv_i(1, 32'h300);
    #1 chk("lock0.m_addr", m_bus.address, 32'h300); chk("lock0.i_wait", i_bus.waitrequest, 1);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      drv_d(0, 1, 32'h40, 4'hF, 32'h1234_5678);
      #1 chk("lock.m_addr", m_bus.address, 32'h300); chk("lock.d_wait", d_bus.waitrequest, 1);
      chk("lock.m_write", m_bus.write, 0);
    end
    @(negedge clk);
    drv_m(0, 0, 0);
    #1 chk("lock3.m_addr", m_bus.address, 32'h300); chk("lock3.m_read", m_bus.read, 1);
    chk("lock3.i_wait", i_bus.waitrequest, 0); chk("lock3.d_wait", d_bus.waitrequest, 1);
    @(negedge clk);
    drv_i(0, 0);
    #1 chk("lock4.m_write", m_bus.write, 1); chk("lock4.m_addr", m_bus.address, 32'h40);
    chk("lock4.m_wd", m_bus.writedata, 32'h1234_5678); chk("lock4.d_wait", d_bus.waitrequest, 0);
    @(negedge clk);
    drv_d(0, 0, 0, 0, 0); drv_m(0, 1, 32'hCCCC);
    #1 chk("lock5.i_rdv", i_bus.readdatavalid, 1); chk("lock5.i_data", i_bus.readdata, 32'hCCCC);

    // ---- plain write forwarding
    @(negedge clk);
    drv_m(0, 0, 0); drv_d(0, 1, 32'h40, 4'b0011, 32'hDEAD_BEEF);
    #1 chk("wr.m_write", m_bus.write, 1); chk("wr.m_read", m_bus.read, 0);
    chk("wr.m_addr", m_bus.address, 32'h40); chk("wr.m_wd", m_bus.writedata, 32'hDEAD_BEEF);
    chk("wr.m_be", m_bus.byteenable, 4'b0011); chk("wr.d_wait", d_bus.waitrequest, 0);
    chk("wr.d_rdv", d_bus.readdatavalid, 0); chk("wr.i_rdv", i_bus.readdatavalid, 0);
    @(negedge clk);
    drv_d(0, 0, 0, 0, 0);
    #1 chk("wr2.d_rdv", d_bus.readdatavalid, 0); chk("wr2.i_rdv", i_bus.readdatavalid, 0);

    // ---- fill the tag FIFO; fifth read stalls until a response frees a slot
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drv_i(1, 32'h400 + 4 * k);
      #1 chk("fill.i_wait", i_bus.waitrequest, 0); chk("fill.m_addr", m_bus.address, 32'h400 + 4 * k);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv_i(1, 32'h410);
      #1 chk("full.i_wait", i_bus.waitrequest, 1); chk("full.m_read", m_bus.read, 0);
    end
    @(negedge clk);
    drv_m(0, 1, 32'h1000);
    #1 chk("full_pop.i_rdv", i_bus.readdatavalid, 1); chk("full_pop.data", i_bus.readdata, 32'h1000);
    chk("full_pop.i_wait", i_bus.waitrequest, 1);
    @(negedge clk);
    drv_m(0, 0, 0);
    #1 chk("fifth.i_wait", i_bus.waitrequest, 0); chk("fifth.m_addr", m_bus.address, 32'h410);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drv_i(0, 0); drv_m(0, 1, 32'h1000 + k);
      #1 chk("drain.i_rdv", i_bus.readdatavalid, 1); chk("drain.i_data", i_bus.readdata, 32'h1000 + k);
      chk("drain.d_rdv", d_bus.readdatavalid, 0);
    end

    // ---- reset with reads outstanding
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drv_m(0, 0, 0); drv_d(1, 0, 32'h500 + 4 * k, 4'hF, 0);
      #1 chk("pre_rst.d_wait", d_bus.waitrequest, 0);
    end
    @(negedge clk);
    drv_d(1, 0, 32'h508, 4'hF, 0); drv_i(1, 32'h600); drv_m(0, 1, 32'h7777);
    #2 rst = 1'b0;
    #1 chk_reset_outs("mid_rst");
    @(negedge clk);
    drv_m(0, 0, 0); rst = 1'b1;
    #1 chk("post_rst.m_addr", m_bus.address, 32'h508); chk("post_rst.d_wait", d_bus.waitrequest, 0);
    chk("post_rst.i_wait", i_bus.waitrequest, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drv_d(0, 0, 0, 0, 0); drv_i(1, 32'h600 + 4 * k);
      #1 chk("post_rst.fill", i_bus.waitrequest, 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drv_i(0, 0); drv_m(0, 1, 32'h2000 + k);
      #1 chk("post_rst.d_rdv", d_bus.readdatavalid, (k == 0));
      chk("post_rst.i_rdv", i_bus.readdatavalid, (k != 0));
    end

    // ---- randomized two-host traffic
    d_act = 0; i_act = 0; d_cur = '0; i_cur = '0; cyc = 0;
    while (cyc < 1500 || d_act || i_act || mq.size() != 0) begin
      @(negedge clk);
      if (cyc >= 6000) begin
        chk("drain_timeout", cyc, 0);
        break;
      end
      if (!d_act && cyc < 1500 && $urandom_range(0, 2) != 0) begin
        d_act = 1;
        d_cur.read = ($urandom_range(0, 2) != 0);
        d_cur.write = !d_cur.read;
        d_cur.address = {$urandom, 2'b00};
        d_cur.byteenable = 4'($urandom);
        d_cur.writedata = $urandom;
      end
      if (!i_act && cyc < 1500 && $urandom_range(0, 2) != 0) begin
        i_act = 1;
        i_cur = '0;
        i_cur.read = 1;
        i_cur.address = {$urandom, 2'b00};
      end
      if (d_act) drv_d(d_cur.read, d_cur.write, d_cur.address, d_cur.byteenable, d_cur.writedata);
      else       drv_d(0, 0, 0, 0, 0);
      drv_i(i_act, i_cur.address);
      if (mq.size() != 0 && mq[0].rdy <= cyc && $urandom_range(0, 3) != 0)
        drv_m($urandom_range(0, 3) == 0, 1, mq[0].data);
      else
        drv_m($urandom_range(0, 3) == 0, 0, $urandom);
      #1;
      if (m_bus.readdatavalid) begin
        void'(mq.pop_front());
        if (order.size() == 0) chk("rnd.spurious", 1, 0);
        else begin
          p = order.pop_front();
          chk("rnd.d_rdv", d_bus.readdatavalid, (p == PortData));
          chk("rnd.i_rdv", i_bus.readdatavalid, (p == PortInstr));
          if (p == PortData) begin a = d_rq.pop_front(); chk("rnd.d_data", d_bus.readdata, memf(a)); end
          else begin a = i_rq.pop_front(); chk("rnd.i_data", i_bus.readdata, memf(a)); end
        end
      end else begin
        chk("rnd.no_rdv", {d_bus.readdatavalid, i_bus.readdatavalid}, 0);
      end
      d_acc = d_act && !d_bus.waitrequest;
      i_acc = i_act && !i_bus.waitrequest;
      m_acc = (m_bus.read || m_bus.write) && !m_bus.waitrequest;
      chk("rnd.one_grant", d_acc & i_acc, 0);
      chk("rnd.acc_match", m_acc, d_acc | i_acc);
      if (d_acc) begin
        if (d_cur.read) begin d_rq.push_back(d_cur.address); order.push_back(PortData); end
        else dw_q.push_back(d_cur);
        d_act = 0;
      end
      if (i_acc) begin
        i_rq.push_back(i_cur.address); order.push_back(PortInstr);
        i_act = 0;
      end
      if (m_acc && m_bus.read)
        mq.push_back('{data: memf(m_bus.address), rdy: cyc + int'($urandom_range(1, 3))});
      if (m_acc && m_bus.write) begin
        if (dw_q.size() == 0) chk("rnd.wr_unexpected", 1, 0);
        else begin
          w = dw_q.pop_front();
          chk("rnd.wr_addr", m_bus.address, w.address);
          chk("rnd.wr_data", m_bus.writedata, w.writedata);
          chk("rnd.wr_be", m_bus.byteenable, w.byteenable);
        end
      end
      if (mq.size() > MAXP) chk("rnd.pending", mq.size(), MAXP);
      cyc++;
    end
    chk("rnd.left_d", d_rq.size(), 0);
    chk("rnd.left_i", i_rq.size(), 0);
    chk("rnd.left_w", dw_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
